wb_rr_arbiter_ct: RTL and testbench



---
 rtl/wb_arb_pkg.sv | 44 ++++
 rtl/rr_arb_pick.sv | 37 +++
 rtl/wb_rr_arbiter_ct.sv | 206 ++++++++++++++++++++
 tb/tb_wb_rr_arbiter_ct.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg
// Shared definitions for the round-robin Wishbone arbiter:
//   - arb_state_t : arbiter FSM states (IDLE, BUSY, ABORT)
//   - CTI_*       : Wishbone B3 cycle-type encodings used by masters
//   - rr_pick()   : reference round-robin pick over up to MAX_MASTERS requesters,
//                   returning a one-hot grant (zero when nothing requests)
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        ABORT = 2'd2
    } arb_state_t;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam int MAX_MASTERS = 8;

    // Search upward from ptr+1 with wrap-around over the first n requesters.
    function automatic logic [MAX_MASTERS-1:0] rr_pick(
        input logic [MAX_MASTERS-1:0] req,
        input int                     ptr,
        input int                     n
    );
        logic [MAX_MASTERS-1:0] gnt;
        logic                   found;
        int                     c;
        gnt   = '0;
        found = 1'b0;
        for (int i = 1; i <= MAX_MASTERS; i++) begin
            if (i <= n && !found) begin
                c = (ptr + i) % n;
                if (req[c]) begin
                    gnt[c] = 1'b1;
                    found  = 1'b1;
                end
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/rr_arb_pick.sv
// rr_arb_pick
// Combinational round-robin picker: rotates the request vector so that the
// entry after ptr lands at bit 0, takes the lowest set bit, and rotates the
// one-hot result back. Output is zero when no request is set.
// Ports:
//   req   in  WIDTH  request vector
//   ptr   in  PTR_W  index of the last owner (lowest priority)
//   grant out WIDTH  one-hot pick
module rr_arb_pick #(
    parameter int WIDTH = 3,
    parameter int PTR_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [WIDTH-1:0] grant
);

    logic [2*WIDTH-1:0] req2;
    logic [2*WIDTH-1:0] oh2;
    logic [WIDTH-1:0]   rot;
    logic [WIDTH-1:0]   first;
    int                 shamt;

    always_comb begin
        // Rotation amount is ptr+1, reduced into 0..WIDTH-1.
        shamt = int'(ptr) + 1;
        if (shamt >= WIDTH) begin
            shamt = shamt - WIDTH;
        end
        req2  = {req, req};
        rot   = req2[shamt +: WIDTH];
        first = rot & (~rot + WIDTH'(1));
        oh2   = {first, first};
        grant = oh2[(WIDTH - shamt) +: WIDTH];
    end

endmodule

// File: rtl/wb_rr_arbiter_ct.sv
// wb_rr_arbiter_ct
// Round-robin Wishbone B3 arbiter sharing one slave port among MASTERS masters.
// A grant covers a whole bus cycle (held while the owner keeps cyc high), so
// bursts and read-modify-write sequences are never interleaved. Grant is
// registered; the address/data/control mux toward the slave is combinational.
//
// Optional feature macro: WB_ARB_TIMEOUT_EN
//   When defined, a watchdog terminates a strobe left unanswered for
//   TIMEOUT_CYCLES cycles with an error to the owner and an ABORT state that
//   keeps the slave cycle closed until the owner releases cyc.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   m_adr_i/m_dat_i/m_sel_i         per-master address/write data/byte select (master k at slice k)
//   m_we_i/m_cyc_i/m_stb_i          per-master control
//   m_cti_i/m_bte_i                 per-master cycle/burst type
//   m_ack_o/m_err_o/m_rty_o         per-master responses (owner bit only)
//   m_dat_o                         read data broadcast to all masters
//   s_*_o                           slave-side request signals from the owner
//   s_ack_i/s_err_i/s_rty_i/s_dat_i slave responses
//   grant_o                         one-hot current owner, zero when idle
module wb_rr_arbiter_ct
    import wb_arb_pkg::*;
#(
    parameter int MASTERS        = 3,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [MASTERS*ADDR_WIDTH-1:0] m_adr_i,
    input  logic [MASTERS*DATA_WIDTH-1:0] m_dat_i,
    input  logic [MASTERS*DATA_WIDTH/8-1:0] m_sel_i,
    input  logic [MASTERS-1:0]            m_we_i,
    input  logic [MASTERS-1:0]            m_cyc_i,
    input  logic [MASTERS-1:0]            m_stb_i,
    input  logic [MASTERS*3-1:0]          m_cti_i,
    input  logic [MASTERS*2-1:0]          m_bte_i,
    output logic [MASTERS-1:0]            m_ack_o,
    output logic [MASTERS-1:0]            m_err_o,
    output logic [MASTERS-1:0]            m_rty_o,
    output logic [DATA_WIDTH-1:0]         m_dat_o,
    output logic [ADDR_WIDTH-1:0]         s_adr_o,
    output logic [DATA_WIDTH-1:0]         s_dat_o,
    output logic [DATA_WIDTH/8-1:0]       s_sel_o,
    output logic                          s_we_o,
    output logic                          s_cyc_o,
    output logic                          s_stb_o,
    output logic [2:0]                    s_cti_o,
    output logic [1:0]                    s_bte_o,
    input  logic                          s_ack_i,
    input  logic                          s_err_i,
    input  logic                          s_rty_i,
    input  logic [DATA_WIDTH-1:0]         s_dat_i,
    output logic [MASTERS-1:0]            grant_o
);

    localparam int SEL_W = DATA_WIDTH / 8;
    localparam int PTR_W = $clog2(MASTERS);

    if (MASTERS < 2 || MASTERS > MAX_MASTERS) begin : g_bad_masters
        $error("wb_rr_arbiter_ct: MASTERS must be in 2..8");
    end
    if (DATA_WIDTH % 8 != 0) begin : g_bad_width
        $error("wb_rr_arbiter_ct: DATA_WIDTH must be a multiple of 8");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("wb_rr_arbiter_ct: TIMEOUT_CYCLES must fit the 8-bit watchdog");
    end

    arb_state_t         state_q, state_d;
    logic [MASTERS-1:0] grant_q, grant_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [MASTERS-1:0] pick;
    logic [PTR_W-1:0]   owner_idx;
    logic               owner_cyc;
    logic               owner_stb;
    logic               bus_live;
    logic               timeout_hit;

    logic [ADDR_WIDTH-1:0] mux_adr;
    logic [DATA_WIDTH-1:0] mux_dat;
    logic [SEL_W-1:0]      mux_sel;
    logic [2:0]            mux_cti;
    logic [1:0]            mux_bte;

    rr_arb_pick #(
        .WIDTH (MASTERS),
        .PTR_W (PTR_W)
    ) u_pick (
        .req   (m_cyc_i),
        .ptr   (ptr_q),
        .grant (pick)
    );

    // Owner index and AND-OR datapath mux; everything is zero while no grant is held.
    always_comb begin
        owner_idx = '0;
        mux_adr   = '0;
        mux_dat   = '0;
        mux_sel   = '0;
        mux_cti   = '0;
        mux_bte   = '0;
        for (int k = 0; k < MASTERS; k++) begin
            if (grant_q[k]) begin
                owner_idx = PTR_W'(k);
                mux_adr   = mux_adr | m_adr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
                mux_dat   = mux_dat | m_dat_i[k*DATA_WIDTH +: DATA_WIDTH];
                mux_sel   = mux_sel | m_sel_i[k*SEL_W +: SEL_W];
                mux_cti   = mux_cti | m_cti_i[k*3 +: 3];
                mux_bte   = mux_bte | m_bte_i[k*2 +: 2];
            end
        end
    end

    assign owner_cyc = |(m_cyc_i & grant_q);
    assign owner_stb = |(m_stb_i & grant_q);

`ifdef WB_ARB_TIMEOUT_EN
    logic [7:0] wd_cnt;

    assign timeout_hit = (state_q == BUSY) && (wd_cnt == 8'(TIMEOUT_CYCLES));

    // Watchdog counts consecutive strobe cycles with no slave response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= '0;
        end else if (s_ack_i || s_err_i || s_rty_i || !s_stb_o) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + 8'd1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // The slave cycle is open only in BUSY, and is cut in the cycle the watchdog fires.
    assign bus_live = (state_q == BUSY) && !timeout_hit;

    assign s_adr_o = mux_adr;
    assign s_dat_o = mux_dat;
    assign s_sel_o = mux_sel;
    assign s_cti_o = mux_cti;
    assign s_bte_o = mux_bte;
    assign s_we_o  = |(m_we_i & grant_q);
    assign s_cyc_o = bus_live & owner_cyc;
    assign s_stb_o = bus_live & owner_cyc & owner_stb;

    assign m_ack_o = grant_q & {MASTERS{s_ack_i & s_stb_o}};
    assign m_err_o = grant_q & {MASTERS{(s_err_i & s_stb_o) | timeout_hit}};
    assign m_rty_o = grant_q & {MASTERS{s_rty_i & s_stb_o}};
    assign m_dat_o = s_dat_i;
    assign grant_o = grant_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= PTR_W'(MASTERS - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    // Releasing the bus records the owner as the new lowest-priority master.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (|m_cyc_i) begin
                    grant_d = pick;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (timeout_hit) begin
                    state_d = ABORT;
                end else if (!owner_cyc) begin
                    state_d = IDLE;
                    grant_d = '0;
                    ptr_d   = owner_idx;
                end
            end
`ifdef WB_ARB_TIMEOUT_EN
            ABORT: begin
                if (!owner_cyc) begin
                    state_d = IDLE;
                    grant_d = '0;
                    ptr_d   = owner_idx;
                end
            end
`endif
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_wb_rr_arbiter_ct.sv
// tb_wb_rr_arbiter_ct
// Self-checking bench for wb_rr_arbiter_ct (3 masters, 32-bit address/data).
// A per-cycle vector table, directed multi-cycle sequences, and a randomized
// phase compared against a behavioural owner/pointer model.
// With WB_ARB_TIMEOUT_EN defined the watchdog sequence and model are enabled.
module tb_wb_rr_arbiter_ct;
    import wb_arb_pkg::*;

    localparam int M  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [M*AW-1:0] m_adr_i;
    logic [M*DW-1:0] m_dat_i;
    logic [M*SW-1:0] m_sel_i;
    logic [M-1:0]    m_we_i, m_cyc_i, m_stb_i;
    logic [M*3-1:0]  m_cti_i;
    logic [M*2-1:0]  m_bte_i;
    logic [M-1:0]    m_ack_o, m_err_o, m_rty_o;
    logic [DW-1:0]   m_dat_o;
    logic [AW-1:0]   s_adr_o;
    logic [DW-1:0]   s_dat_o;
    logic [SW-1:0]   s_sel_o;
    logic            s_we_o, s_cyc_o, s_stb_o;
    logic [2:0]      s_cti_o;
    logic [1:0]      s_bte_o;
    logic            s_ack_i, s_err_i, s_rty_i;
    logic [DW-1:0]   s_dat_i;
    logic [M-1:0]    grant_o;

    always #5 clk = ~clk;

    wb_rr_arbiter_ct #(
        .MASTERS        (M),
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .m_adr_i (m_adr_i),
        .m_dat_i (m_dat_i),
        .m_sel_i (m_sel_i),
        .m_we_i  (m_we_i),
        .m_cyc_i (m_cyc_i),
        .m_stb_i (m_stb_i),
        .m_cti_i (m_cti_i),
        .m_bte_i (m_bte_i),
        .m_ack_o (m_ack_o),
        .m_err_o (m_err_o),
        .m_rty_o (m_rty_o),
        .m_dat_o (m_dat_o),
        .s_adr_o (s_adr_o),
        .s_dat_o (s_dat_o),
        .s_sel_o (s_sel_o),
        .s_we_o  (s_we_o),
        .s_cyc_o (s_cyc_o),
        .s_stb_o (s_stb_o),
        .s_cti_o (s_cti_o),
        .s_bte_o (s_bte_o),
        .s_ack_i (s_ack_i),
        .s_err_i (s_err_i),
        .s_rty_i (s_rty_i),
        .s_dat_i (s_dat_i),
        .grant_o (grant_o)
    );

    int checks = 0;
    int fails  = 0;

    typedef struct {
        logic [2:0]  cyc;
        logic [2:0]  stb;
        logic        ack;
        logic        err;
        logic        rty;
        logic [31:0] sdat;
        logic [2:0]  egnt;
        logic [2:0]  eack;
        logic [2:0]  eerr;
        logic [2:0]  erty;
        logic        escyc;
        logic        esstb;
    } vec_t;

    vec_t vecs[20];

    // Behavioural model state: owner index (-1 = none), last owner, watchdog count.
    int mOwner;
    int mPtr;
    int mCnt;
    bit mAbort;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        m_adr_i = '0; m_dat_i = '0; m_sel_i = '0; m_we_i = '0;
        m_cyc_i = '0; m_stb_i = '0; m_cti_i = '0; m_bte_i = '0;
        s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0; s_dat_i = '0;
    endtask

    task automatic setMaster(input int k, input logic cyc, input logic stb, input logic we,
                             input logic [31:0] adr, input logic [31:0] dat,
                             input logic [3:0] sel, input logic [2:0] cti);
        m_cyc_i[k]            = cyc;
        m_stb_i[k]            = stb;
        m_we_i[k]             = we;
        m_adr_i[k*AW +: AW]   = adr;
        m_dat_i[k*DW +: DW]   = dat;
        m_sel_i[k*SW +: SW]   = sel;
        m_cti_i[k*3 +: 3]     = cti;
        m_bte_i[k*2 +: 2]     = 2'b00;
    endtask

    task automatic applyReset();
        rst_n = 1'b0;
        clearInputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset grant", grant_o, 0);
        checkOutput("reset s_cyc", s_cyc_o, 0);
        checkOutput("reset s_stb", s_stb_o, 0);
        checkOutput("reset m_ack", m_ack_o, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mOwner = -1;
        mPtr   = M - 1;
        mCnt   = 0;
        mAbort = 0;
    endtask

    task automatic applyStimulus(input vec_t v);
        m_cyc_i = v.cyc;
        m_stb_i = v.stb;
        s_ack_i = v.ack;
        s_err_i = v.err;
        s_rty_i = v.rty;
        s_dat_i = v.sdat;
    endtask

    function automatic logic [31:0] tableAdr(input logic [2:0] g);
        logic [31:0] a;
        a = 32'h0;
        for (int k = 0; k < M; k++) begin
            if (g[k]) a = 32'h1000 + 32'h100 * k;
        end
        return a;
    endfunction

    function automatic int pickNext(input logic [2:0] req, input int ptr);
        for (int i = 1; i <= M; i++) begin
            if (req[(ptr + i) % M]) return (ptr + i) % M;
        end
        return -1;
    endfunction

    // Randomized phase: compare one cycle of outputs against the model, then advance it.
    task automatic modelCycle();
        logic [2:0]  eg;
        logic        toHit;
        logic        ecyc, estb;
        logic [31:0] eadr, edat;
        logic [3:0]  esel;
        eg    = (mOwner >= 0) ? 3'(1 << mOwner) : 3'b000;
        toHit = 1'b0;
`ifdef WB_ARB_TIMEOUT_EN
        toHit = (mOwner >= 0) && !mAbort && (mCnt == TO);
`endif
        ecyc = 1'b0;
        estb = 1'b0;
        if (mOwner >= 0 && !mAbort && !toHit) begin
            ecyc = m_cyc_i[mOwner];
            estb = m_cyc_i[mOwner] & m_stb_i[mOwner];
        end
        eadr = (mOwner >= 0) ? m_adr_i[mOwner*AW +: AW] : 32'h0;
        edat = (mOwner >= 0) ? m_dat_i[mOwner*DW +: DW] : 32'h0;
        esel = (mOwner >= 0) ? m_sel_i[mOwner*SW +: SW] : 4'h0;
        checkOutput("rnd grant", grant_o, eg);
        checkOutput("rnd s_cyc", s_cyc_o, ecyc);
        checkOutput("rnd s_stb", s_stb_o, estb);
        checkOutput("rnd s_adr", s_adr_o, eadr);
        checkOutput("rnd s_dat", s_dat_o, edat);
        checkOutput("rnd s_sel", s_sel_o, esel);
        checkOutput("rnd m_ack", m_ack_o, (estb && s_ack_i) ? eg : 3'b000);
        checkOutput("rnd m_err", m_err_o, ((estb && s_err_i) || toHit) ? eg : 3'b000);
        checkOutput("rnd m_rty", m_rty_o, (estb && s_rty_i) ? eg : 3'b000);
        checkOutput("rnd m_dat", m_dat_o, s_dat_i);
        mCnt = (s_ack_i || s_err_i || s_rty_i || !estb) ? 0 : mCnt + 1;
        if (mOwner < 0) begin
            mOwner = pickNext(m_cyc_i, mPtr);
        end else if (toHit) begin
            mAbort = 1;
        end else if (!m_cyc_i[mOwner]) begin
            mPtr   = mOwner;
            mOwner = -1;
            mAbort = 0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] time limit");
    end

    initial begin
        //             cyc     stb     ack   err   rty   sdat          egnt    eack    eerr    erty    scyc  sstb
        vecs[0]  = '{3'b111, 3'b111, 1'b0, 1'b0, 1'b0, 32'h0,        3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0};
        vecs[1]  = '{3'b111, 3'b111, 1'b1, 1'b0, 1'b0, 32'h1111_0000, 3'b001, 3'b001, 3'b000, 3'b000, 1'b1, 1'b1};
        vecs[2]  = '{3'b110, 3'b110, 1'b0, 1'b0, 1'b0, 32'h5A5A_0002, 3'b001, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0};
        vecs[3]  = '{3'b110, 3'b110, 1'b0, 1'b0, 1'b0, 32'h0,        3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0};
        vecs[4]  = '{3'b110, 3'b110, 1'b1, 1'b0, 1'b0, 32'h1111_0001, 3'b010, 3'b010, 3'b000, 3'b000, 1'b1, 1'b1};
        vecs[5]  = '{3'b100, 3'b100, 1'b0, 1'b0, 1'b0, 32'h0,        3'b010, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0};
        vecs[6]  = '{3'b100, 3'b100, 1'b0, 1'b0, 1'b0, 32'h0,        3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0};
        vecs[7]  = '{3'b100, 3'b100, 1'b1, 1'b0, 1'b0, 32'h1111_0002, 3'b100, 3'b100, 3'b000, 3'b000, 1'b1, 1'b1};
        vecs[8]  = '{3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0,        3'b100, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0};
        vecs[9]  = '{3'b010, 3'b010, 1'b0, 1'b0, 1'b0, 32'h0,        3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0};
        vecs[10] = '{3'b010, 3'b010, 1'b0, 1'b0, 1'b1, 32'h0,        3'b010, 3'b000, 3'b000, 3'b010, 1'b1, 1'b1};
        vecs[11] = '{3'b010, 3'b000, 1'b1, 1'b0, 1'b0, 32'h0,        3'b010, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0};
        vecs[12] = '{3'b010, 3'b010, 1'b0, 1'b1, 1'b0, 32'h0,        3'b010, 3'b000, 3'b010, 3'b000, 1'b1, 1'b1};
        vecs[13] = '{3'b010, 3'b010, 1'b1, 1'b0, 1'b0, 32'hCAFE_0013, 3'b010, 3'b010, 3'b000, 3'b000, 1'b1, 1'b1};
        vecs[14] = '{3'b001, 3'b001, 1'b0, 1'b0, 1'b0, 32'h0,        3'b010, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0};
        vecs[15] = '{3'b001, 3'b001, 1'b0, 1'b0, 1'b0, 32'h0,        3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0};
        vecs[16] = '{3'b011, 3'b011, 1'b1, 1'b0, 1'b0, 32'h0,        3'b001, 3'b001, 3'b000, 3'b000, 1'b1, 1'b1};
        vecs[17] = '{3'b010, 3'b010, 1'b0, 1'b0, 1'b0, 32'h0,        3'b001, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0};
        vecs[18] = '{3'b011, 3'b011, 1'b0, 1'b0, 1'b0, 32'h0,        3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0};
        vecs[19] = '{3'b011, 3'b011, 1'b1, 1'b0, 1'b0, 32'h0,        3'b010, 3'b010, 3'b000, 3'b000, 1'b1, 1'b1};

        // Vector table: arbitration order, turnaround, response gating.
        applyReset();
        for (int k = 0; k < M; k++) begin
            setMaster(k, 1'b0, 1'b0, 1'b0, 32'h1000 + 32'h100 * k, 32'h0, 4'hF, CTI_CLASSIC);
        end
        for (int i = 0; i < 20; i++) begin
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkOutput($sformatf("vec%0d grant", i), grant_o, vecs[i].egnt);
            checkOutput($sformatf("vec%0d m_ack", i), m_ack_o, vecs[i].eack);
            checkOutput($sformatf("vec%0d m_err", i), m_err_o, vecs[i].eerr);
            checkOutput($sformatf("vec%0d m_rty", i), m_rty_o, vecs[i].erty);
            checkOutput($sformatf("vec%0d s_cyc", i), s_cyc_o, vecs[i].escyc);
            checkOutput($sformatf("vec%0d s_stb", i), s_stb_o, vecs[i].esstb);
            checkOutput($sformatf("vec%0d s_adr", i), s_adr_o, tableAdr(vecs[i].egnt));
            checkOutput($sformatf("vec%0d m_dat", i), m_dat_o, vecs[i].sdat);
            @(posedge clk);
            #1;
        end

        // Master 1 single write, slave acks two cycles after the strobe.
        applyReset();
        setMaster(1, 1'b1, 1'b1, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 4'hF, CTI_CLASSIC);
        @(negedge clk);
        checkOutput("wr grant latency", grant_o, 3'b000);
        tick();
        @(negedge clk);
        checkOutput("wr grant", grant_o, 3'b010);
        checkOutput("wr s_adr", s_adr_o, 32'h0000_0040);
        checkOutput("wr s_dat", s_dat_o, 32'hDEAD_BEEF);
        checkOutput("wr s_sel", s_sel_o, 4'hF);
        checkOutput("wr s_we", s_we_o, 1'b1);
        checkOutput("wr no early ack", m_ack_o, 3'b000);
        tick();
        tick();
        s_ack_i = 1'b1;
        @(negedge clk);
        checkOutput("wr m_ack", m_ack_o, 3'b010);
        tick();
        s_ack_i = 1'b0;
        setMaster(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, CTI_CLASSIC);
        @(negedge clk);
        checkOutput("wr ack one cycle", m_ack_o, 3'b000);
        checkOutput("wr release grant", grant_o, 3'b010);
        tick();
        @(negedge clk);
        checkOutput("wr idle after", grant_o, 3'b000);

        // Master 0 four-beat incrementing burst while master 2 waits.
        applyReset();
        setMaster(0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 4'hF, CTI_INCR);
        setMaster(2, 1'b1, 1'b1, 1'b0, 32'h0000_0300, 32'h0, 4'hF, CTI_CLASSIC);
        @(negedge clk);
        checkOutput("burst idle", grant_o, 3'b000);
        tick();
        for (int b = 0; b < 4; b++) begin
            m_adr_i[0 +: AW]  = 32'(b * 4);
            m_cti_i[0 +: 3]   = (b == 3) ? CTI_EOB : CTI_INCR;
            s_ack_i           = 1'b1;
            @(negedge clk);
            checkOutput($sformatf("burst%0d grant", b), grant_o, 3'b001);
            checkOutput($sformatf("burst%0d s_adr", b), s_adr_o, 32'(b * 4));
            checkOutput($sformatf("burst%0d s_cti", b), s_cti_o, (b == 3) ? CTI_EOB : CTI_INCR);
            checkOutput($sformatf("burst%0d m_ack", b), m_ack_o, 3'b001);
            @(posedge clk);
            #1;
        end
        s_ack_i    = 1'b0;
        m_cyc_i[0] = 1'b0;
        m_stb_i[0] = 1'b0;
        @(negedge clk);
        checkOutput("burst release grant", grant_o, 3'b001);
        checkOutput("burst release s_cyc", s_cyc_o, 1'b0);
        tick();
        @(negedge clk);
        checkOutput("burst turnaround", grant_o, 3'b000);
        tick();
        @(negedge clk);
        checkOutput("burst next grant", grant_o, 3'b100);
        checkOutput("burst next s_adr", s_adr_o, 32'h0000_0300);

        // Asynchronous reset in the middle of master 1's burst.
        applyReset();
        setMaster(1, 1'b1, 1'b1, 1'b1, 32'h0000_0200, 32'h1234_5678, 4'hF, CTI_INCR);
        tick();
        s_ack_i = 1'b1;
        tick();
        tick();
        @(negedge clk);
        checkOutput("rst precondition grant", grant_o, 3'b010);
        #2;
        rst_n = 1'b0;
        setMaster(0, 1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'hF, CTI_CLASSIC);
        #1;
        checkOutput("rst grant", grant_o, 3'b000);
        checkOutput("rst s_cyc", s_cyc_o, 1'b0);
        checkOutput("rst s_stb", s_stb_o, 1'b0);
        checkOutput("rst s_adr", s_adr_o, 32'h0);
        checkOutput("rst s_dat", s_dat_o, 32'h0);
        checkOutput("rst s_we", s_we_o, 1'b0);
        checkOutput("rst m_ack", m_ack_o, 3'b000);
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        s_ack_i = 1'b0;
        @(negedge clk);
        checkOutput("rst release idle", grant_o, 3'b000);
        tick();
        @(negedge clk);
        checkOutput("rst master0 first", grant_o, 3'b001);

`ifdef WB_ARB_TIMEOUT_EN
        // Hung slave: watchdog error, abort, then hand-over after release.
        applyReset();
        setMaster(0, 1'b1, 1'b1, 1'b0, 32'h0000_0500, 32'h0, 4'hF, CTI_CLASSIC);
        @(negedge clk);
        checkOutput("wd idle", grant_o, 3'b000);
        tick();
        for (int c = 0; c < TO; c++) begin
            @(negedge clk);
            checkOutput($sformatf("wd quiet%0d", c), m_err_o, 3'b000);
            checkOutput($sformatf("wd stb%0d", c), s_stb_o, 1'b1);
            @(posedge clk);
            #1;
        end
        setMaster(1, 1'b1, 1'b1, 1'b0, 32'h0000_0600, 32'h0, 4'hF, CTI_CLASSIC);
        @(negedge clk);
        checkOutput("wd err pulse", m_err_o, 3'b001);
        checkOutput("wd s_cyc cut", s_cyc_o, 1'b0);
        checkOutput("wd s_stb cut", s_stb_o, 1'b0);
        tick();
        s_ack_i = 1'b1;
        @(negedge clk);
        checkOutput("wd abort grant", grant_o, 3'b001);
        checkOutput("wd abort s_cyc", s_cyc_o, 1'b0);
        checkOutput("wd abort ack dropped", m_ack_o, 3'b000);
        checkOutput("wd err single", m_err_o, 3'b000);
        tick();
        s_ack_i    = 1'b0;
        m_cyc_i[0] = 1'b0;
        m_stb_i[0] = 1'b0;
        @(negedge clk);
        checkOutput("wd abort hold", grant_o, 3'b001);
        tick();
        @(negedge clk);
        checkOutput("wd idle turnaround", grant_o, 3'b000);
        tick();
        @(negedge clk);
        checkOutput("wd next grant", grant_o, 3'b010);
`endif

        // Randomized traffic against the behavioural model.
        applyReset();
        for (int n = 0; n < 3000; n++) begin
            for (int k = 0; k < M; k++) begin
                if ($urandom_range(7) == 0) m_cyc_i[k] = ~m_cyc_i[k];
                m_stb_i[k]          = ($urandom_range(3) != 0);
                m_we_i[k]           = $urandom_range(1) == 1;
                m_adr_i[k*AW +: AW] = $urandom;
                m_dat_i[k*DW +: DW] = $urandom;
                m_sel_i[k*SW +: SW] = 4'($urandom_range(15));
                m_cti_i[k*3 +: 3]   = 3'($urandom_range(7));
            end
            s_ack_i = ($urandom_range(5) == 0);
            s_err_i = ($urandom_range(15) == 0);
            s_rty_i = ($urandom_range(15) == 0);
            s_dat_i = $urandom;
            @(negedge clk);
            modelCycle();
            @(posedge clk);
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
